// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset boot sequencer: the FSM state
// encoding and the limits used by the parameter legality check.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } seq_state_t;

  localparam int NUM_DOMAINS_MIN = 1;
  localparam int NUM_DOMAINS_MAX = 16;
  localparam int CYCLES_MIN      = 1;
  localparam int STAGGER_MIN     = 1;
  localparam int WDT_CYCLES_MIN  = 1;

endpackage

// File: rtl/reset_seq_domain_pulse.sv
// One domain's reset pulse stretcher: a trigger holds pulse high for
// STAGGER cycles starting at the next edge; re-triggering restarts the
// count, and clear aborts it.
module reset_seq_domain_pulse #(
  parameter int STAGGER = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic trigger,
  output logic pulse
);

  localparam int PW = $clog2(STAGGER + 1);

  logic [PW-1:0] cnt_reg;

  // Remaining pulse cycles; loads STAGGER (its maximum) and counts down to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (trigger) begin
      cnt_reg <= PW'(STAGGER);
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign pulse = (cnt_reg != '0);

endmodule

// File: rtl/reset_boot_sequencer.sv
// Reset boot sequencer: holds all domains in reset for CYCLES clocks,
// releases them one by one STAGGER clocks apart, then supports soft
// re-sequencing and per-domain reset pulses.
// Optional watchdog is built only when RESET_SEQ_WATCHDOG_EN is defined.
module reset_boot_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 2,
  parameter int CYCLES      = 20,
  parameter int STAGGER     = 4,
  parameter int WDT_CYCLES  = 1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   soft_req,
  input  logic [NUM_DOMAINS-1:0] dom_req,
  input  logic                   heartbeat,
  output logic [NUM_DOMAINS-1:0] reset_o,
  output logic                   ready,
  output logic                   wdt_fired
);

  // One counter serves both the HOLD wait and the RELEASE stagger.
  localparam int CNT_MAX = (CYCLES > STAGGER) ? CYCLES : STAGGER;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_DOMAINS + 1);

  if (NUM_DOMAINS < NUM_DOMAINS_MIN || NUM_DOMAINS > NUM_DOMAINS_MAX ||
      CYCLES < CYCLES_MIN || STAGGER < STAGGER_MIN ||
      WDT_CYCLES < WDT_CYCLES_MIN) begin : g_bad_params
    $error("reset_boot_sequencer: parameter out of legal range");
  end

  seq_state_t             state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;   // number of domains released
  logic [NUM_DOMAINS-1:0] release_mask;
  logic [NUM_DOMAINS-1:0] pulse;
  logic [NUM_DOMAINS-1:0] trigger;
  logic                   wdt_trip;
  logic                   restart;

  // A soft request or a watchdog timeout restarts the whole sequence.
  assign restart = soft_req || wdt_trip;

  // Sequencer state, counter and release index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= HOLD;
      cnt_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
    end
  end

  // Next-state logic for the HOLD -> RELEASE -> RUN sequence.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    case (state_reg)
      HOLD: begin
        if (soft_req) begin
          cnt_next = '0;
        end else if (cnt_reg == CNT_W'(CYCLES - 1)) begin
          state_next = (NUM_DOMAINS == 1) ? RUN : RELEASE;
          cnt_next   = '0;
          idx_next   = IDX_W'(1);
        end else if (cnt_reg < CNT_W'(CNT_MAX)) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RELEASE: begin
        if (soft_req) begin
          state_next = HOLD;
          cnt_next   = '0;
          idx_next   = '0;
        end else if (cnt_reg == CNT_W'(STAGGER - 1)) begin
          cnt_next = '0;
          idx_next = idx_reg + 1'b1;
          if (idx_reg == IDX_W'(NUM_DOMAINS - 1)) begin
            state_next = RUN;
          end
        end else if (cnt_reg < CNT_W'(CNT_MAX)) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RUN: begin
        if (restart) begin
          state_next = HOLD;
          cnt_next   = '0;
          idx_next   = '0;
        end
      end
      default: begin
        state_next = HOLD;
        cnt_next   = '0;
        idx_next   = '0;
      end
    endcase
  end

  // Per-domain release mask and pulse stretchers.
  for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_dom
    assign release_mask[gi] = (IDX_W'(gi) >= idx_reg);
    assign trigger[gi]      = (state_reg == RUN) && !restart && dom_req[gi];

    reset_seq_domain_pulse #(
      .STAGGER (STAGGER)
    ) u_pulse (
      .clk     (clk),
      .reset   (reset),
      .clear   (restart),
      .trigger (trigger[gi]),
      .pulse   (pulse[gi])
    );
  end

  // Outputs decode only async-reset registers, so reset assertion is seen
  // without waiting for a clock edge.
  always_comb begin
    reset_o = '1;
    ready   = 1'b0;
    case (state_reg)
      RELEASE: reset_o = release_mask;
      RUN: begin
        reset_o = pulse;
        ready   = ~|pulse;
      end
      default: ;
    endcase
  end

`ifdef RESET_SEQ_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);

  logic [WDT_W-1:0] wdt_reg;
  logic             fired_reg;

  assign wdt_trip  = (state_reg == RUN) && !heartbeat &&
                     (wdt_reg == WDT_W'(WDT_CYCLES - 1));
  assign wdt_fired = fired_reg;

  // Watchdog counts RUN cycles since the last heartbeat; fired flag is sticky.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdt_reg   <= '0;
      fired_reg <= 1'b0;
    end else begin
      if (state_reg != RUN || heartbeat || wdt_trip) begin
        wdt_reg <= '0;
      end else if (wdt_reg < WDT_W'(WDT_CYCLES)) begin
        wdt_reg <= wdt_reg + 1'b1;
      end
      if (wdt_trip) begin
        fired_reg <= 1'b1;
      end
    end
  end
`else
  logic unused_heartbeat;
  assign unused_heartbeat = heartbeat;
  assign wdt_trip         = 1'b0;
  assign wdt_fired        = 1'b0;
`endif

endmodule

// File: tb/tb_reset_boot_sequencer.sv
// Testbench for reset_boot_sequencer (3 domains, CYCLES=20, STAGGER=4,
// WDT_CYCLES=100). Expected outputs come from a timeline model: each
// domain's release edge is seq_start + CYCLES + i*STAGGER, and each pulse
// is an end-edge number per domain.
module tb_reset_boot_sequencer;

  localparam int ND  = 3;
  localparam int CYC = 20;
  localparam int STG = 4;
  localparam int WDT = 100;

  logic          clk;
  logic          reset;
  logic          soft_req;
  logic [ND-1:0] dom_req;
  logic          heartbeat;
  logic [ND-1:0] reset_o;
  logic          ready;
  logic          wdt_fired;

  int checks = 0;
  int passes = 0;

  // Reference timeline
  int cyc        = 0;         // edges seen while out of reset
  int seq_start  = 0;         // edge at which the hold count restarted
  int last_hb    = -1000000;  // edge of most recent heartbeat
  int pulse_end[ND];          // first edge at which a domain pulse is over
  bit exp_fired  = 1'b0;

  reset_boot_sequencer #(
    .NUM_DOMAINS (ND),
    .CYCLES      (CYC),
    .STAGGER     (STG),
    .WDT_CYCLES  (WDT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .soft_req  (soft_req),
    .dom_req   (dom_req),
    .heartbeat (heartbeat),
    .reset_o   (reset_o),
    .ready     (ready),
    .wdt_fired (wdt_fired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_reset_o"}, 32'(reset_o), 32'(3'b111));
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_wdt_fired"}, 32'(wdt_fired), 32'd0);
  endtask

  task automatic model_clear();
    for (int i = 0; i < ND; i++) pulse_end[i] = 0;
  endtask

  // One clock with the given inputs, model update, then output check.
  task automatic tick(input logic s, input logic [ND-1:0] d, input logic h);
    int      run_at;
    int      kick;
    bit      pre_run;
    bit      trip;
    logic [ND-1:0] exp_ro;
    logic    exp_rdy;
    soft_req  = s;
    dom_req   = d;
    heartbeat = h;
    @(posedge clk);
    cyc++;
    run_at  = seq_start + CYC + (ND - 1) * STG;
    pre_run = (cyc - 1) >= run_at;
    trip    = 1'b0;
    kick    = (last_hb > run_at) ? last_hb : run_at;
`ifdef RESET_SEQ_WATCHDOG_EN
    if (pre_run && !h && (cyc - kick) >= WDT) trip = 1'b1;
`endif
    if (h) last_hb = cyc;
    if (s || trip) begin
      seq_start = cyc;
      model_clear();
      if (trip) exp_fired = 1'b1;
    end else if (pre_run) begin
      for (int i = 0; i < ND; i++) if (d[i]) pulse_end[i] = cyc + STG;
    end
    #1;
    run_at  = seq_start + CYC + (ND - 1) * STG;
    exp_rdy = (cyc >= run_at);
    for (int i = 0; i < ND; i++) begin
      exp_ro[i] = (cyc < seq_start + CYC + i * STG) || (cyc < pulse_end[i]);
      if (cyc < pulse_end[i]) exp_rdy = 1'b0;
    end
    $display("cyc=%0d soft=%0b dom=%03b hb=%0b reset_o=%03b ready=%0b wdt_fired=%0b kick=%0d",
             cyc, s, d, h, reset_o, ready, wdt_fired, kick);
    chk("reset_o", 32'(reset_o), 32'(exp_ro));
    chk("ready", 32'(ready), 32'(exp_rdy));
    chk("wdt_fired", 32'(wdt_fired), 32'(exp_fired));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, '0, 1'b0);
  endtask

  // Hold reset low for n edges, then release it between edges.
  task automatic apply_reset(input int n);
    reset = 1'b0;
    #1;
    chk_reset_values("async_assert");
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      chk_reset_values("in_reset");
    end
    @(negedge clk);
    reset     = 1'b1;
    seq_start = cyc;
    last_hb   = -1000000;
    exp_fired = 1'b0;
    model_clear();
  endtask

  initial begin
    reset     = 1'b0;
    soft_req  = 1'b0;
    dom_req   = '0;
    heartbeat = 1'b0;
    model_clear();
    #1;
    chk_reset_values("por");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk_reset_values("por_hold");
    end
    @(negedge clk);
    reset = 1'b1;
    seq_start = cyc;

    // Power-on release sequence
    idle(32);

    // Soft re-sequence from RUN
    tick(1'b1, '0, 1'b0);
    idle(32);

    // Single domain pulse, then a pulse extended by a re-request
    tick(1'b0, 3'b010, 1'b0);
    idle(6);
    tick(1'b0, 3'b010, 1'b0);
    idle(1);
    tick(1'b0, 3'b010, 1'b0);
    idle(8);

    // soft_req and dom_req together: soft_req wins
    tick(1'b1, 3'b100, 1'b0);
    idle(34);

    // Soft request during HOLD restarts the count; during RELEASE restarts it too
    tick(1'b1, '0, 1'b0);
    idle(10);
    tick(1'b1, '0, 1'b0);
    idle(22);
    tick(1'b1, '0, 1'b0);
    idle(30);

    // dom_req during HOLD/RELEASE is ignored
    tick(1'b1, '0, 1'b0);
    for (int k = 0; k < 30; k++) tick(1'b0, 3'($urandom_range(0, 7)), 1'b0);

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      logic          s;
      logic [ND-1:0] d;
      logic          h;
      s = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < ND; i++) d[i] = ($urandom_range(0, 7) == 0);
      h = ($urandom_range(0, 19) == 0);
      tick(s, d, h);
    end

    // Settle into RUN, then heartbeat every 50 cycles
    tick(1'b1, '0, 1'b0);
    idle(30);
    for (int k = 0; k < 160; k++) tick(1'b0, '0, (k % 50) == 49);

    // Long stretch without heartbeat
    idle(130);

    // Asynchronous reset mid-RELEASE (reset_o = 3'b110)
    tick(1'b1, '0, 1'b0);
    idle(21);
    chk("pre_abort_reset_o", 32'(reset_o), 32'(3'b110));
    #2;
    apply_reset(2);

    // Asynchronous reset during a domain pulse
    idle(32);
    tick(1'b0, 3'b001, 1'b0);
    idle(1);
    #2;
    apply_reset(1);
    idle(32);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/reset_boot_sequencer.md
RESET_BOOT_SEQUENCER -- requirements
Module: reset_boot_sequencer

Interface
REQ-001 Parameter NUM_DOMAINS, default 2: number of independently released reset domains, legal range 1..16.
REQ-002 Parameter CYCLES, default 20: clk cycles all domains are held in reset before the first release, minimum 1.
REQ-003 Parameter STAGGER, default 4: clk cycles between releases of consecutive domains, and length of a per-domain reset pulse, minimum 1.
REQ-004 Parameter WDT_CYCLES, default 1000000: watchdog timeout in clk cycles, used only when RESET_SEQ_WATCHDOG_EN is defined.
REQ-005 clk  input  1  single clock; all sequential logic is on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low block reset.
REQ-007 soft_req  input  1  synchronous request to re-run the full reset sequence.
REQ-008 dom_req  input  NUM_DOMAINS  per-domain synchronous reset-pulse requests.
REQ-009 heartbeat  input  1  watchdog kick from the core domain.
REQ-010 reset_o  output  NUM_DOMAINS  active-high domain resets; bit 0 is released first.
REQ-011 ready  output  1  high when all domains are out of reset.
REQ-012 wdt_fired  output  1  sticky flag, set when a watchdog timeout has occurred.

Function
REQ-013 The FSM SHALL have exactly three states: HOLD (all reset_o high, counting CYCLES), RELEASE (releasing domains in index order), and RUN.
REQ-014 HOLD SHALL move to RELEASE and drive reset_o[0] low on the CYCLES-th rising edge after reset deasserts.
REQ-015 RELEASE SHALL drive reset_o[i] low STAGGER edges after reset_o[i-1]; on the edge releasing the last domain, the FSM SHALL enter RUN and ready SHALL go high.
REQ-016 With NUM_DOMAINS=1, HOLD SHALL go directly to RUN on the CYCLES-th edge.
REQ-017 A soft_req seen in RUN or RELEASE SHALL, on the next edge, drive all reset_o high, drive ready low, and enter HOLD with the counter cleared.
REQ-018 A soft_req seen in HOLD SHALL restart the HOLD counter.
REQ-019 A dom_req[i] seen in RUN SHALL drive reset_o[i] high from the next edge for exactly STAGGER cycles; other domains are unaffected.
REQ-020 A dom_req[i] re-asserted while domain i's pulse is active SHALL restart that pulse count.
REQ-021 ready SHALL be low while any domain pulse is active.
REQ-022 dom_req SHALL be ignored in HOLD and RELEASE.
REQ-023 When soft_req and any dom_req bit are high in the same cycle, soft_req SHALL win and all pulse counters SHALL clear.
REQ-024 Counter widths SHALL be $clog2(max value + 1); counters SHALL saturate and never wrap.

Reset
REQ-025 reset low SHALL immediately, with no clk edge, set reset_o to all ones, ready=0, wdt_fired=0, state HOLD, and all counters to 0.
REQ-026 Asserting reset in any state, including mid-RELEASE or during a domain pulse, SHALL abort the current activity with the REQ-025 values.

Configuration
REQ-027 With RESET_SEQ_WATCHDOG_EN defined, a watchdog counter SHALL run in RUN, clearing on heartbeat; if it reaches WDT_CYCLES, the block SHALL perform the REQ-017 action and set wdt_fired, which stays set until reset.
REQ-028 With RESET_SEQ_WATCHDOG_EN undefined, no watchdog logic SHALL exist, heartbeat SHALL be ignored, and wdt_fired SHALL be tied to 0.

Structure
REQ-029 Package reset_seq_pkg SHALL hold the FSM state encoding (HOLD, RELEASE, RUN) and the parameter legality-check constants.
REQ-030 Sub-module reset_seq_domain_pulse SHALL implement one domain's STAGGER-cycle pulse stretcher and be instantiated NUM_DOMAINS times.
REQ-031 An elaboration-time check SHALL fail for out-of-range NUM_DOMAINS, CYCLES or STAGGER.

Verification (NUM_DOMAINS=3, CYCLES=20, STAGGER=4, WDT_CYCLES=100)
REQ-032 Power-on: reset low for 5 cycles then high -> reset_o[0] falls at edge 20, reset_o[1] at edge 24, reset_o[2] at edge 28; ready rises at edge 28.
REQ-033 soft_req pulse in RUN -> reset_o=3'b111 and ready=0 next edge; releases then repeat at +20, +24 and +28 edges.
REQ-034 dom_req=3'b010 for one cycle in RUN -> reset_o=3'b010 for 4 cycles then 3'b000; ready low for those 4 cycles; a re-request at cycle 2 extends the pulse to 6 cycles.
REQ-035 soft_req and dom_req=3'b100 in the same cycle -> full sequence only; no separate pulse on reset_o[2] after RUN is reached.
REQ-036 reset driven low between clk edges mid-RELEASE (reset_o=3'b110) -> reset_o=3'b111 and ready=0 before the next edge.
REQ-037 Watchdog enabled, no heartbeat -> 100 cycles into RUN a full re-sequence starts and wdt_fired=1; with heartbeat every 50 cycles -> no re-sequence; macro undefined -> wdt_fired stays 0.
